// File: rtl/misr_response_compactor_if.sv
// Adder-response bus into the compactor: valid/ready handshake carrying sum and carry-out.
// Source drives in_valid/in_sum/in_cout; the compactor drives in_ready.
interface misr_response_compactor_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;

    modport master (output in_valid, output in_sum, output in_cout, input in_ready);
    modport slave  (input in_valid, input in_sum, input in_cout, output in_ready);
endinterface

// File: rtl/misr_response_compactor.sv
// MISR response compactor: folds accepted adder sums into a signature and compares it with golden.
// Latency: signature updates on the accepting edge; done rises on the edge accepting the last response.
// Backpressure: in_ready only in RUN. Optional MISR_COUT_FOLD_EN folds carry-out into bit 0.
module misr_response_compactor #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_patterns,
    input  logic [WIDTH-1:0]            golden,
    misr_response_compactor_if.slave    rsp,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            signature,
    output logic [CNT_W-1:0]            pattern_cnt,
    output logic                        pass,
    output logic                        fail
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sig_nxt;
    logic [WIDTH-1:0] fold;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] target;
    logic             done_entry;

`ifdef MISR_COUT_FOLD_EN
    assign fold = {rsp.in_sum[WIDTH-1:1], rsp.in_sum[0] ^ rsp.in_cout};
`else
    logic unused_cout;
    assign unused_cout = rsp.in_cout;
    assign fold        = rsp.in_sum;
`endif

    always_comb begin
        state_nxt = state;
        sig_nxt   = signature;
        cnt_nxt   = pattern_cnt;
        unique case (state)
            IDLE: ;
            RUN: begin
                if (rsp.in_valid) begin
                    sig_nxt = {signature[WIDTH-2:0], 1'b0}
                            ^ (signature[WIDTH-1] ? POLY : '0)
                            ^ fold;
                    cnt_nxt = pattern_cnt + 1'b1;
                    if (cnt_nxt == target)
                        state_nxt = DONE;
                end
            end
            DONE: ;
            default: state_nxt = IDLE;
        endcase
        // start overrides any response presented in the same cycle
        if (start) begin
            sig_nxt   = SEED;
            cnt_nxt   = '0;
            state_nxt = (num_patterns == '0) ? DONE : RUN;
        end
    end

    // Re-arming from DONE straight back into DONE (zero patterns) is still an entry.
    assign done_entry = (state_nxt == DONE) && ((state != DONE) || start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            signature   <= SEED;
            pattern_cnt <= '0;
            target      <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            signature   <= sig_nxt;
            pattern_cnt <= cnt_nxt;
            if (start)
                target <= num_patterns;
            if (done_entry) begin
                pass <= (sig_nxt == golden);
                fail <= (sig_nxt != golden);
            end else if (start) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end
        end
    end

    assign rsp.in_ready = (state == RUN);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);
endmodule

// File: tb/tb_misr_response_compactor.sv
// Bench for misr_response_compactor: directed literal checks plus randomized runs against a behavioural model.
// Every cycle all outputs are compared with the model at the falling edge.
module tb_misr_response_compactor;
    localparam int          W    = 32;
    localparam int          CW   = 16;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'h0;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_patterns;
    logic [W-1:0]  golden;
    logic          busy, done, pass, fail;
    logic [W-1:0]  signature;
    logic [CW-1:0] pattern_cnt;

    misr_response_compactor_if #(.WIDTH(W)) bus ();

    misr_response_compactor dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .golden       (golden),
        .rsp          (bus),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .pattern_cnt  (pattern_cnt),
        .pass         (pass),
        .fail         (fail)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    int          m_state = M_IDLE;
    logic [31:0] m_sig   = SEED;
    int          m_cnt   = 0;
    int          m_tgt   = 0;
    logic        m_pass  = 1'b0;
    logic        m_fail  = 1'b0;

    // Signature arithmetic: multiply by x modulo POLY over GF(2), then add the response word.
    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] sum, input logic cout);
        logic [31:0] d;
        d = sum;
`ifdef MISR_COUT_FOLD_EN
        d[0] = d[0] ^ cout;
`endif
        return ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = M_IDLE; m_sig = SEED; m_cnt = 0; m_tgt = 0; m_pass = 0; m_fail = 0;
        end else if (start) begin
            m_sig = SEED; m_cnt = 0; m_tgt = int'(num_patterns);
            m_pass = 0; m_fail = 0;
            m_state = (num_patterns == 0) ? M_DONE : M_RUN;
            if (m_state == M_DONE) begin
                m_pass = (m_sig == golden); m_fail = !m_pass;
            end
        end else if (m_state == M_RUN && bus.in_valid) begin
            m_sig = misr(m_sig, bus.in_sum, bus.in_cout);
            m_cnt++;
            if (m_cnt == m_tgt) begin
                m_state = M_DONE;
                m_pass = (m_sig == golden); m_fail = !m_pass;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready",    64'(bus.in_ready), 64'(m_state == M_RUN));
        chk("busy",        64'(busy),         64'(m_state == M_RUN));
        chk("done",        64'(done),         64'(m_state == M_DONE));
        chk("signature",   64'(signature),    64'(m_sig));
        chk("pattern_cnt", 64'(pattern_cnt),  64'(m_cnt));
        chk("pass",        64'(pass),         64'(m_pass));
        chk("fail",        64'(fail),         64'(m_fail));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic start_run(input int n, input logic [31:0] g);
        start = 1'b1; num_patterns = CW'(n); golden = g;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] sum, input logic cout);
        bus.in_valid = 1'b1; bus.in_sum = sum; bus.in_cout = cout;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] sums [8];
        logic        couts[8];
        logic [31:0] exp_sig;
        logic [31:0] cout_exp;
        int          n;

        rst = 1'b1; start = 1'b0; num_patterns = '0; golden = '0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_cout = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        chk("reset_sig", 64'(signature), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        // Single pattern: signature becomes the word itself, golden matches
        start_run(1, 32'h1);
        send(32'h1, 1'b0);
        chk("n1_sig", 64'(signature), 64'h1);
        chk("n1_done", 64'(done), 64'h1);
        chk("n1_pass", 64'(pass), 64'h1);

        start_run(2, 32'h3);
        send(32'h1, 1'b0);
        send(32'h0, 1'b0);
        chk("n2_sig", 64'(signature), 64'h2);
        chk("n2_cnt", 64'(pattern_cnt), 64'h2);
        chk("n2_fail", 64'(fail), 64'h1);

        // MSB shift-out applies POLY; idle gap must not disturb the signature
        start_run(2, 32'h04C11DB7);
        send(32'h8000_0000, 1'b0);
        repeat (5) step();
        chk("gap_sig", 64'(signature), 64'h8000_0000);
        send(32'h0, 1'b0);
        chk("poly_sig", 64'(signature), 64'h04C11DB7);
        chk("poly_pass", 64'(pass), 64'h1);

        send(32'hFFFF, 1'b1);
        chk("done_ignore_sig", 64'(signature), 64'h04C11DB7);
        chk("done_ready", 64'(bus.in_ready), 64'h0);

        rst = 1'b1; step(); rst = 1'b0;
        send(32'h5, 1'b0);
        chk("idle_ignore_sig", 64'(signature), 64'h0);

        start_run(0, 32'h0);
        chk("zero_done", 64'(done), 64'h1);
        chk("zero_sig", 64'(signature), 64'(SEED));
        chk("zero_pass", 64'(pass), 64'h1);

        start_run(3, 32'h0);
        send(32'h7, 1'b0);
        start_run(3, 32'h0);
        chk("abort_sig", 64'(signature), 64'(SEED));
        chk("abort_cnt", 64'(pattern_cnt), 64'h0);
        send(32'h9, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_sig", 64'(signature), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // start and a response together: response dropped
        start = 1'b1; num_patterns = 16'd2; bus.in_valid = 1'b1; bus.in_sum = 32'hABCD;
        step();
        start = 1'b0; bus.in_valid = 1'b0;
        chk("start_wins_cnt", 64'(pattern_cnt), 64'h0);

        start_run(1, 32'h0);
        send(32'h0, 1'b1);
`ifdef MISR_COUT_FOLD_EN
        cout_exp = 32'h1;
`else
        cout_exp = 32'h0;
`endif
        chk("cout_sig", 64'(signature), 64'(cout_exp));

        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 8);
            exp_sig = SEED;
            for (int i = 0; i < n; i++) begin
                sums[i]  = $urandom;
                couts[i] = 1'($urandom);
                exp_sig  = misr(exp_sig, sums[i], couts[i]);
            end
            start_run(n, ($urandom_range(0, 1) == 1) ? exp_sig : $urandom);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_sum = $urandom;
                    step();
                end
                send(sums[i], couts[i]);
            end
            chk("rand_sig", 64'(signature), 64'(exp_sig));
            chk("rand_pass", 64'(pass), 64'(golden == exp_sig));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
